// File: rtl/jacaranda_pkg.sv
// rtl/jacaranda_pkg.sv - shared register map, bit positions and FSM states for the jacaranda Wishbone loader
package jacaranda_pkg;

  localparam int IMEM_AW = 8;

  localparam logic [11:0] OFF_CTRL       = 12'h000;
  localparam logic [11:0] OFF_STATUS     = 12'h004;
  localparam logic [11:0] OFF_IMEM_BASE  = 12'h400;
  localparam logic [11:0] OFF_IMEM_LIMIT = 12'h7FC;

  localparam int CTRL_RUN_BIT     = 0;
  localparam int CTRL_CLR_ERR_BIT = 1;
  localparam int STAT_RUN_BIT     = 0;
  localparam int STAT_ERR_BIT     = 1;
  localparam int STAT_CNT_LSB     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } wb_state_e;

  function automatic logic is_imem_off(input logic [11:0] off);
    return (off >= OFF_IMEM_BASE) && (off <= OFF_IMEM_LIMIT + 12'd3);
  endfunction

endpackage

// File: rtl/jacaranda_wb_loader.sv
// rtl/jacaranda_wb_loader.sv - Wishbone program loader and run/halt control for jacaranda-8
// Optional IMEM readback path enabled by JACARANDA_WB_LOADER_READBACK_EN.
module jacaranda_wb_loader
  import jacaranda_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [7:0]         imem_wdata_o,
  input  logic [7:0]         imem_rdata_i,
  output logic               cpu_rst_no
);

  localparam logic [IMEM_AW-1:0] IDX_MASK = IMEM_AW'(IMEM_DEPTH - 1);

  wb_state_e          state;
  logic               run;
  logic               err;
  logic [7:0]         load_cnt;
  logic [IMEM_AW-1:0] addr_q;

  logic [11:0]        offset;
  logic               hit;
  logic               req;
  logic               is_imem;
  logic               is_ctrl;
  logic               is_status;
  logic               rd_via_wait;
  logic [IMEM_AW-1:0] idx;
  logic [31:0]        rd_data;

  assign offset    = wbs_adr_i[11:0];
  assign hit       = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req       = wbs_cyc_i & wbs_stb_i & hit;
  assign is_imem   = is_imem_off(offset);
  assign is_ctrl   = (offset == OFF_CTRL);
  assign is_status = (offset == OFF_STATUS);
  assign idx       = wbs_adr_i[9:2] & IDX_MASK;

`ifdef JACARANDA_WB_LOADER_READBACK_EN
  assign rd_via_wait = req & is_imem & ~wbs_we_i;
`else
  assign rd_via_wait = 1'b0;
`endif

  // Address goes straight through while a request is being accepted so the
  // synchronous memory already has the word by the time RD_WAIT samples it.
  assign imem_addr_o = (state == ST_IDLE && req && is_imem) ? idx : addr_q;

  assign cpu_rst_no = run;

  always_comb begin
    rd_data = '0;
    if (is_ctrl) begin
      rd_data[CTRL_RUN_BIT] = run;
    end else if (is_status) begin
      rd_data[STAT_RUN_BIT]        = run;
      rd_data[STAT_ERR_BIT]        = err;
      rd_data[STAT_CNT_LSB +: 8]   = load_cnt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= ST_IDLE;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      imem_we_o    <= 1'b0;
      imem_wdata_o <= '0;
      addr_q       <= '0;
      run          <= 1'b0;
      err          <= 1'b0;
      load_cnt     <= '0;
    end else begin
      imem_we_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          if (req) begin
            if (is_imem) addr_q <= idx;
            if (rd_via_wait) begin
              state <= ST_RD_WAIT;
            end else begin
              state     <= ST_ACK;
              wbs_ack_o <= 1'b1;
              if (!wbs_we_i) begin
                wbs_dat_o <= rd_data;
              end else if (wbs_sel_i[0]) begin
                if (is_imem) begin
                  if (run) begin
                    err <= 1'b1;
                  end else begin
                    imem_we_o    <= 1'b1;
                    imem_wdata_o <= wbs_dat_i[7:0];
                    load_cnt     <= load_cnt + 8'd1;
                  end
                end else if (is_ctrl) begin
                  run <= wbs_dat_i[CTRL_RUN_BIT];
                  if (wbs_dat_i[CTRL_RUN_BIT] && !run) load_cnt <= '0;
                  if (wbs_dat_i[CTRL_CLR_ERR_BIT]) err <= 1'b0;
                end
              end
            end
          end
        end
        ST_RD_WAIT: begin
          if (!wbs_cyc_i) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= {24'b0, imem_rdata_i};
          end
        end
        ST_ACK: begin
          state     <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:8], wbs_sel_i[3:1], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_jacaranda_wb_loader.sv
// tb/tb_jacaranda_wb_loader.sv - self-checking bench for jacaranda_wb_loader
module tb_jacaranda_wb_loader;

`ifdef JACARANDA_WB_LOADER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] dat_o;
  logic        imem_we;
  logic [7:0]  imem_addr, imem_wdata, imem_rdata;
  logic        cpu_rst_n;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jacaranda_wb_loader dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .imem_rdata_i(imem_rdata),
    .cpu_rst_no  (cpu_rst_n)
  );

  // Synchronous instruction memory seen by the loader.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (imem_we) ram[imem_addr] <= imem_wdata;
    imem_rdata <= ram[imem_addr];
  end

  // Reference model state.
  logic       ref_run, ref_err;
  int         ref_cnt;
  logic [7:0] ref_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ref_run = 1'b0;
    ref_err = 1'b0;
    ref_cnt = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input logic [3:0] s, output logic [31:0] rd, output int lat,
                              output logic sw, output logic [7:0] sa, output logic [7:0] sd);
    int  off;
    int  ix;
    bit  imem;
    off  = int'(a[11:0]);
    ix   = (off / 4) % 256;
    imem = (off >= 'h400) && (off < 'h800);
    rd = 0; lat = 1; sw = 0; sa = 0; sd = 0;
    if (!w) begin
      if (imem) begin
        lat = RB ? 2 : 1;
        rd  = RB ? {24'h0, ref_mem[ix]} : 32'h0;
      end else if (off == 0) begin
        rd = {31'h0, ref_run};
      end else if (off == 4) begin
        rd = ref_cnt * 256 + (ref_err ? 2 : 0) + (ref_run ? 1 : 0);
      end
    end else if (s[0]) begin
      if (imem) begin
        if (ref_run) begin
          ref_err = 1'b1;
        end else begin
          ref_mem[ix] = d[7:0];
          ref_cnt = (ref_cnt + 1) % 256;
          sw = 1; sa = ix[7:0]; sd = d[7:0];
        end
      end else if (off == 0) begin
        if (d[0] && !ref_run) ref_cnt = 0;
        ref_run = d[0];
        if (d[1]) ref_err = 1'b0;
      end
    end
  endtask

  task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input logic [3:0] s, output logic [31:0] rd, output int lat,
                           output logic sw, output logic [7:0] sa, output logic [7:0] sd,
                           output logic cpu, output logic we_after, output logic ack_after);
    cyc = 1; stb = 1; we = w; sel = s; adr = a; wdat = d;
    rd = 0; lat = 0; sw = 0; sa = 0; sd = 0; cpu = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (imem_we) begin sw = 1; sa = imem_addr; sd = imem_wdata; end
      if (ack) begin lat = i; rd = dat_o; cpu = cpu_rst_n; break; end
    end
    cyc = 0; stb = 0; we = 0; sel = 0;
    @(posedge clk); #1;
    we_after = imem_we;
    ack_after = ack;
  endtask

  task automatic checked_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic [3:0] s);
    logic [31:0] erd, grd;
    int          elat, glat;
    logic        esw, gsw, gcpu, gwa, gaa;
    logic [7:0]  esa, esd, gsa, gsd;
    model_access(a, d, w, s, erd, elat, esw, esa, esd);
    do_access(a, d, w, s, grd, glat, gsw, gsa, gsd, gcpu, gwa, gaa);
    check({tag, "_latency"}, glat, elat);
    check({tag, "_rdata"}, grd, erd);
    check({tag, "_strobe"}, gsw, esw);
    if (esw) begin
      check({tag, "_addr"}, gsa, esa);
      check({tag, "_wdata"}, gsd, esd);
    end
    check({tag, "_cpu_rst_n"}, gcpu, ref_run);
    check({tag, "_ack_one_cycle"}, gaa, 1'b0);
    check({tag, "_we_one_cycle"}, gwa, 1'b0);
  endtask

  task automatic do_reset();
    cyc = 0; stb = 0; we = 0; sel = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", imem_addr, 8'h0);
    check("rst_imem_wdata", imem_wdata, 8'h0);
    check("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_sw;
    logic [7:0]  exp_sa;
    logic [7:0]  exp_sd;
    logic        exp_cpu;
  } vec_t;

  localparam logic [31:0] B = 32'h3000_0000;

  initial begin
    vec_t        tbl [22];
    logic [31:0] grd, mrd;
    int          glat, mlat;
    logic        gsw, gcpu, gwa, gaa, msw;
    logic [7:0]  gsa, gsd, msa, msd;
    int          acks;

    for (int i = 0; i < 256; i++) begin ram[i] = 8'h0; ref_mem[i] = 8'h0; end
    model_reset();

    tbl[0]  = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 0};
    tbl[1]  = '{B + 32'h408, 32'hA5,      1, 4'h1, 32'h0,               1,      1, 8'h02, 8'hA5, 0};
    tbl[2]  = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h100,             1,      0, 8'h00, 8'h00, 0};
    tbl[3]  = '{B + 32'h408, 32'h0,       0, 4'hF, RB ? 32'hA5 : 32'h0, RB + 1, 0, 8'h00, 8'h00, 0};
    tbl[4]  = '{B + 32'h000, 32'h1,       1, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 1};
    tbl[5]  = '{B + 32'h400, 32'h11,      1, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 1};
    tbl[6]  = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h3,               1,      0, 8'h00, 8'h00, 1};
    tbl[7]  = '{B + 32'h000, 32'h3,       1, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 1};
    tbl[8]  = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h1,               1,      0, 8'h00, 8'h00, 1};
    tbl[9]  = '{B + 32'h000, 32'h0,       0, 4'hF, 32'h1,               1,      0, 8'h00, 8'h00, 1};
    tbl[10] = '{B + 32'h00C, 32'hFFFF_FFFF, 1, 4'hF, 32'h0,             1,      0, 8'h00, 8'h00, 1};
    tbl[11] = '{B + 32'h00C, 32'h0,       0, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 1};
    tbl[12] = '{B + 32'h000, 32'h0,       1, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 0};
    tbl[13] = '{B + 32'h404, 32'h5A,      1, 4'h2, 32'h0,               1,      0, 8'h00, 8'h00, 0};
    tbl[14] = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 0};
    tbl[15] = '{B + 32'h404, 32'h5A,      1, 4'hF, 32'h0,               1,      1, 8'h01, 8'h5A, 0};
    tbl[16] = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h100,             1,      0, 8'h00, 8'h00, 0};
    tbl[17] = '{B + 32'h400, 32'h0,       0, 4'hF, 32'h0,               RB + 1, 0, 8'h00, 8'h00, 0};
    tbl[18] = '{B + 32'h7FC, 32'h3C,      1, 4'h1, 32'h0,               1,      1, 8'hFF, 8'h3C, 0};
    tbl[19] = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h200,             1,      0, 8'h00, 8'h00, 0};
    tbl[20] = '{B + 32'h800, 32'h77,      1, 4'hF, 32'h0,               1,      0, 8'h00, 8'h00, 0};
    tbl[21] = '{B + 32'h004, 32'h0,       0, 4'hF, 32'h200,             1,      0, 8'h00, 8'h00, 0};

    do_reset();

    for (int i = 0; i < 22; i++) begin
      model_access(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].s, mrd, mlat, msw, msa, msd);
      do_access(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].s, grd, glat, gsw, gsa, gsd, gcpu, gwa, gaa);
      check($sformatf("vec%0d_latency", i), glat, tbl[i].exp_lat);
      check($sformatf("vec%0d_rdata", i), grd, tbl[i].exp_rd);
      check($sformatf("vec%0d_strobe", i), gsw, tbl[i].exp_sw);
      check($sformatf("vec%0d_addr", i), gsa, tbl[i].exp_sa);
      check($sformatf("vec%0d_wdata", i), gsd, tbl[i].exp_sd);
      check($sformatf("vec%0d_cpu_rst_n", i), gcpu, tbl[i].exp_cpu);
      check($sformatf("vec%0d_ack_one_cycle", i), gaa, 1'b0);
      check($sformatf("vec%0d_we_one_cycle", i), gwa, 1'b0);
    end

    // Out-of-window request is ignored entirely.
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_1000; wdat = 32'h1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack || imem_we) acks++;
    end
    cyc = 0; stb = 0; we = 0; sel = 0;
    check("out_of_window_no_ack", acks, 0);
    checked_access("out_of_window_status", B + 32'h004, 32'h0, 0, 4'hF);

`ifdef JACARANDA_WB_LOADER_READBACK_EN
    // IMEM read abandoned while waiting for memory data.
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = B + 32'h410;
    @(posedge clk); #1;
    check("abort_wait_no_ack", ack, 1'b0);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    check("abort_drop_no_ack", ack, 1'b0);
    @(posedge clk); #1;
    check("abort_after_no_ack", ack, 1'b0);
    checked_access("abort_status", B + 32'h004, 32'h0, 0, 4'hF);
`endif

    // LOAD_CNT wrap after 256 writes, then one more.
    do_reset();
    for (int i = 0; i < 256; i++)
      checked_access("wrap_wr", B + 32'h400 + 32'(i * 4), 32'($urandom_range(0, 255)), 1, 4'h1);
    checked_access("wrap_status0", B + 32'h004, 32'h0, 0, 4'hF);
    checked_access("wrap_wr_extra", B + 32'h420, 32'h99, 1, 4'h1);
    checked_access("wrap_status1", B + 32'h004, 32'h0, 0, 4'hF);
    check("wrap_count_is_one", ref_cnt, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic [31:0] a, d;
      logic        w;
      logic [3:0]  s;
      kind = $urandom_range(0, 7);
      d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (kind)
        0:       begin a = B + 32'h000; w = 1; d = 32'($urandom_range(0, 3)); end
        1:       begin a = B + 32'h004; w = 0; end
        2:       begin a = B + 32'h000; w = 0; end
        3, 4:    begin a = B + 32'h400 + 32'($urandom_range(0, 255) * 4); w = 1; end
        5:       begin a = B + 32'h400 + 32'($urandom_range(0, 255) * 4); w = 0; end
        6:       begin a = B + 32'($urandom_range(2, 255) * 4); w = $urandom_range(0, 1); end
        default: begin a = B + 32'h004; w = 1; end
      endcase
      checked_access($sformatf("rand%0d", i), a, d, w, s);
    end

    // Reset asserted while an ack is outstanding.
    checked_access("pre_rst_ctrl0", B + 32'h000, 32'h0, 1, 4'hF);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = B + 32'h000; wdat = 32'h1;
    @(posedge clk); #1;
    check("midrst_ack_before", ack, 1'b1);
    rst_n = 0;
    #1;
    check("midrst_ack_dropped", ack, 1'b0);
    check("midrst_cpu_rst_n", cpu_rst_n, 1'b0);
    check("midrst_dat", dat_o, 32'h0);
    cyc = 0; stb = 0; we = 0; sel = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    checked_access("post_rst_status", B + 32'h004, 32'h0, 0, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
